shift_add_mul_seq: RTL and testbench

//  Sequential unsigned multiplier. Computes a*b as repeated shift-by-1 and conditional add:
//  one multiplier bit is retired per clock.

---
 rtl/shift_add_mul_seq_if.sv | 21 ++
 rtl/shift_add_mul_seq.sv | 81 ++++++++
 tb/tb_shift_add_mul_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/shift_add_mul_seq_if.sv
// shift_add_mul_seq_if: operand/product handshake bundle for the sequential multiplier
interface shift_add_mul_seq_if #(parameter int WIDTH = 4);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/shift_add_mul_seq.sv
// shift_add_mul_seq: unsigned multiplier retiring one multiplier bit per clock by shift and add
module shift_add_mul_seq #(
   parameter int WIDTH = 4
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   shift_add_mul_seq_if.slave bus
);
   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    sum;
   logic             last;

   // Next state: accept in IDLE, one add/shift step per RUN cycle, wait for drain in DONE
   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      prod_d   = prod_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      sum      = mplier_q[0] ? acc_q + mcand_q : acc_q;
      last     = cnt_q == CW'(WIDTH - 1);
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mcand_d  = PW'(bus.a);
               mplier_d = bus.b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (last) begin
               prod_d  = sum;
               state_d = DONE;
            end
         end
         DONE: state_d = bus.out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         prod_q   <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         prod_q   <= prod_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE) && rst_n_i;
   assign bus.out_valid = state_q == DONE;
   assign bus.busy      = state_q != IDLE;
   assign bus.product   = prod_q;
endmodule

// File: tb/tb_shift_add_mul_seq.sv
// tb_shift_add_mul_seq: directed checks of the sequential shift-add multiplier at WIDTH 4 and 8
module tb_shift_add_mul_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   lat;
   time  t1, t2;

   always #5 clk = ~clk;

   shift_add_mul_seq_if #(.WIDTH(4)) bus4 ();
   shift_add_mul_seq_if #(.WIDTH(8)) bus8 ();

   shift_add_mul_seq #(.WIDTH(4)) u4 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus4));
   shift_add_mul_seq #(.WIDTH(8)) u8 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus8));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid4();
      lat = 0;
      while (!bus4.out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   // Accept a*b, check latency, hold DONE for 'hold' cycles, then drain and check retention
   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp, input int hold);
      bus4.a = a;
      bus4.b = b;
      bus4.in_valid = 1'b1;
      bus4.out_ready = 1'b0;
      check("in_ready_idle", 32'(bus4.in_ready), 1);
      tick();
      bus4.in_valid = 1'b0;
      check("busy_run", 32'(bus4.busy), 1);
      wait_valid4();
      check("latency", lat, 4);
      check("product", 32'(bus4.product), 32'(exp));
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold_valid", 32'(bus4.out_valid), 1);
         check("hold_product", 32'(bus4.product), 32'(exp));
      end
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
      check("drain_valid", 32'(bus4.out_valid), 0);
      check("drain_ready", 32'(bus4.in_ready), 1);
      check("retain_product", 32'(bus4.product), 32'(exp));
   endtask

   initial begin
      bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b0;
      bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
      tick();
      tick();
      check("rst_in_ready", 32'(bus4.in_ready), 0);
      check("rst_out_valid", 32'(bus4.out_valid), 0);
      check("rst_busy", 32'(bus4.busy), 0);
      check("rst_product", 32'(bus4.product), 0);
      rst_n = 1'b1;
      #1;
      check("release_ready", 32'(bus4.in_ready), 1);
      tick();

      op4(4'd15, 4'd15, 8'hE1, 0);
      op4(4'd0, 4'd9, 8'h00, 0);
      op4(4'd9, 4'd0, 8'h00, 0);
      op4(4'd7, 4'd3, 8'd21, 5);

      // Abort on the second RUN cycle
      bus4.a = 4'd6; bus4.b = 4'd5; bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      check("abort_ready_low", 32'(bus4.in_ready), 0);
      tick();
      check("abort_busy", 32'(bus4.busy), 0);
      rst_n = 1'b1;
      #1;
      check("abort_ready", 32'(bus4.in_ready), 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("abort_no_valid", 32'(bus4.out_valid), 0);
      end
      op4(4'd2, 4'd3, 8'd6, 0);

      // Operands changing after accept are ignored
      bus4.a = 4'd5; bus4.b = 4'd5; bus4.in_valid = 1'b1;
      tick();
      lat = 0;
      while (!bus4.out_valid && lat < 20) begin
         bus4.a = 4'(lat + 9);
         bus4.b = 4'(lat + 11);
         check("ignore_ready", 32'(bus4.in_ready), 0);
         tick();
         lat++;
      end
      check("ignore_latency", lat, 4);
      check("ignore_ready_done", 32'(bus4.in_ready), 0);
      check("ignore_product", 32'(bus4.product), 25);
      bus4.in_valid = 1'b0;
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
      check("ignore_drain", 32'(bus4.out_valid), 0);

      // WIDTH=8 back-to-back with out_ready tied high
      bus8.a = 8'd255; bus8.b = 8'd255; bus8.in_valid = 1'b1;
      check("w8_ready", 32'(bus8.in_ready), 1);
      @(posedge clk);
      t1 = $time;
      #1;
      bus8.a = 8'd1; bus8.b = 8'd128;
      lat = 0;
      while (!bus8.out_valid && lat < 40) begin tick(); lat++; end
      check("w8_latency", lat, 8);
      check("w8_product1", 32'(bus8.product), 32'hFE01);
      lat = 0;
      while (!bus8.in_ready && lat < 40) begin tick(); lat++; end
      @(posedge clk);
      t2 = $time;
      #1;
      bus8.in_valid = 1'b0;
      check("w8_spacing", 32'((t2 - t1) / 10), 10);
      lat = 0;
      while (!bus8.out_valid && lat < 40) begin tick(); lat++; end
      check("w8_product2", 32'(bus8.product), 32'h0080);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
